trap_scheduler: RTL and testbench

Collects the virtualization trap causes (I/O violations, system IRQ, a programmable virtual timer, and a software request), prioritises them and drives a single registered trap request with an encoded cause toward the trap/mode logic. It tracks the mode logic's `trap_state` through a request/acknowledge/release handshake so only one cause is serviced per trap. It sits between the raw trap sources on the Nabu CPLD and the trap-state flip-flop, and gives the hypervisor a readable pending mask and cause code.

---
 rtl/trap_scheduler_if.sv | 31 +++
 rtl/trap_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_trap_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_scheduler_if.sv
// Trap scheduler bus: raw trap sources and controls in, request/cause/status out.
interface trap_scheduler_if #(
    parameter int TIMER_W = 16
);
    logic               io_violation;
    logic               irq_sys_n;
    logic               trap_state;
    logic               virtual_enabled;
    logic [TIMER_W-1:0] timer_reload;
    logic               sw_set;
    logic [3:0]         cause_clr;
    logic               trap_req;
    logic [1:0]         trap_cause;
    logic [3:0]         pending;
    logic               timer_tick;
    logic               req_timeout;

    // Scheduler side
    modport slave (
        input  io_violation, irq_sys_n, trap_state, virtual_enabled,
               timer_reload, sw_set, cause_clr,
        output trap_req, trap_cause, pending, timer_tick, req_timeout
    );

    // Environment side (trap sources, hypervisor, mode logic)
    modport master (
        output io_violation, irq_sys_n, trap_state, virtual_enabled,
               timer_reload, sw_set, cause_clr,
        input  trap_req, trap_cause, pending, timer_tick, req_timeout
    );
endinterface

// File: rtl/trap_scheduler.sv
// Trap scheduler: synchronizes trap sources, keeps a pending mask, runs the
// virtual timer and drives one registered trap request per trap through a
// request / acknowledge / release handshake with the mode logic.
module trap_scheduler #(
    parameter int TIMER_W = 16,
    parameter int TMO_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    trap_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_TRAP    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] CNT_ZERO = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] CNT_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]   TMO_ZERO = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0]   TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]   TMO_MAX  = {TMO_W{1'b1}};

    // Lowest set index wins: io > sys irq > timer > software.
    function automatic logic [1:0] f_prio(input logic [3:0] p);
        logic [1:0] c;
        if (p[0]) begin
            c = 2'd0;
        end else if (p[1]) begin
            c = 2'd1;
        end else if (p[2]) begin
            c = 2'd2;
        end else begin
            c = 2'd3;
        end
        return c;
    endfunction

    logic               r_io_s1, r_io_s2, r_io_prev;
    logic               r_irq_s1, r_irq_s2;
    logic               r_ts_s1, r_ts_s2;
    logic               r_pend_io, r_pend_tmr, r_pend_sw;
    logic [TIMER_W-1:0] r_cnt;
    logic               r_tick;
    state_t             r_state;
    logic [1:0]         r_cause;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_req;
    logic               r_timeout;

    logic               w_io_rise;
    logic [3:0]         w_pend_live;
    logic [TIMER_W-1:0] w_cnt_nx;
    logic               w_tick_nx;
    logic               w_pend_io_nx, w_pend_tmr_nx, w_pend_sw_nx;
    state_t             w_state_nx;
    logic [1:0]         w_cause_nx;
    logic [TMO_W-1:0]   w_tmo_nx;
    logic               w_tmo_set;
    logic               w_unused;

    // The sys irq bit is a live level; its clear strobe is intentionally ignored.
    assign w_unused    = bus.cause_clr[1];
    assign w_io_rise   = r_io_s2 & ~r_io_prev;
    // Built from flops only, so the mask never sees an input combinationally.
    assign w_pend_live = {r_pend_sw, r_pend_tmr, r_irq_s2, r_pend_io};

    // Two-flop synchronizers for the asynchronous inputs, plus io edge-detect flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_io_s1   <= 1'b0;
            r_io_s2   <= 1'b0;
            r_io_prev <= 1'b0;
            r_irq_s1  <= 1'b0;
            r_irq_s2  <= 1'b0;
            r_ts_s1   <= 1'b0;
            r_ts_s2   <= 1'b0;
        end else begin
            r_io_s1   <= bus.io_violation;
            r_io_s2   <= r_io_s1;
            r_io_prev <= r_io_s2;
            r_irq_s1  <= ~bus.irq_sys_n;
            r_irq_s2  <= r_irq_s1;
            r_ts_s1   <= bus.trap_state;
            r_ts_s2   <= r_ts_s1;
        end
    end

    // Virtual timer next count and expiry tick; holds while trapped.
    always_comb begin
        w_cnt_nx  = r_cnt;
        w_tick_nx = 1'b0;
        if (!bus.virtual_enabled || (bus.timer_reload == CNT_ZERO)) begin
            w_cnt_nx = CNT_ZERO;
        end else if (r_ts_s2) begin
            w_cnt_nx = r_cnt;
        end else if (r_cnt == CNT_ZERO) begin
            w_cnt_nx = bus.timer_reload - CNT_ONE;
        end else begin
            w_cnt_nx  = r_cnt - CNT_ONE;
            w_tick_nx = (r_cnt == CNT_ONE);
        end
    end

    // Latched pending bits: set beats clear, virtualization off clears all.
    always_comb begin
        w_pend_io_nx  = r_pend_io;
        w_pend_tmr_nx = r_pend_tmr;
        w_pend_sw_nx  = r_pend_sw;
        if (!bus.virtual_enabled) begin
            w_pend_io_nx  = 1'b0;
            w_pend_tmr_nx = 1'b0;
            w_pend_sw_nx  = 1'b0;
        end else begin
            if (w_io_rise && !r_ts_s2) begin
                w_pend_io_nx = 1'b1;
            end else if (bus.cause_clr[0]) begin
                w_pend_io_nx = 1'b0;
            end else begin
                w_pend_io_nx = r_pend_io;
            end
            if (w_tick_nx) begin
                w_pend_tmr_nx = 1'b1;
            end else if (bus.cause_clr[2]) begin
                w_pend_tmr_nx = 1'b0;
            end else begin
                w_pend_tmr_nx = r_pend_tmr;
            end
            if (bus.sw_set) begin
                w_pend_sw_nx = 1'b1;
            end else if (bus.cause_clr[3]) begin
                w_pend_sw_nx = 1'b0;
            end else begin
                w_pend_sw_nx = r_pend_sw;
            end
        end
    end

    // Request FSM next state, cause latch and request timeout counter.
    always_comb begin
        w_state_nx = r_state;
        w_cause_nx = r_cause;
        w_tmo_nx   = r_tmo;
        w_tmo_set  = 1'b0;
        if (!bus.virtual_enabled) begin
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((w_pend_live != 4'b0000) && !r_ts_s2) begin
                        w_state_nx = ST_REQ;
                        w_cause_nx = f_prio(w_pend_live);
                        w_tmo_nx   = TMO_ZERO;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (r_ts_s2) begin
                        w_state_nx = ST_TRAP;
                    end else if (r_tmo == TMO_MAX) begin
                        w_tmo_set  = 1'b1;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_tmo_nx = r_tmo + TMO_ONE;
                    end
                end
                ST_TRAP: begin
                    if (!r_ts_s2) begin
                        w_state_nx = ST_RELEASE;
                    end else begin
                        w_state_nx = ST_TRAP;
                    end
                end
                ST_RELEASE: begin
                    w_state_nx = ST_IDLE;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; trap_req is registered from the next state so it moves with trap_cause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_io  <= 1'b0;
            r_pend_tmr <= 1'b0;
            r_pend_sw  <= 1'b0;
            r_cnt      <= CNT_ZERO;
            r_tick     <= 1'b0;
            r_state    <= ST_IDLE;
            r_cause    <= 2'd0;
            r_tmo      <= TMO_ZERO;
            r_req      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_pend_io  <= w_pend_io_nx;
            r_pend_tmr <= w_pend_tmr_nx;
            r_pend_sw  <= w_pend_sw_nx;
            r_cnt      <= w_cnt_nx;
            r_tick     <= w_tick_nx;
            r_state    <= w_state_nx;
            r_cause    <= w_cause_nx;
            r_tmo      <= w_tmo_nx;
            r_req      <= (w_state_nx == ST_REQ);
            r_timeout  <= r_timeout | w_tmo_set;
        end
    end

    assign bus.trap_req    = r_req;
    assign bus.trap_cause  = r_cause;
    assign bus.pending     = w_pend_live;
    assign bus.timer_tick  = r_tick;
    assign bus.req_timeout = r_timeout;
endmodule

// File: tb/tb_trap_scheduler.sv
// Directed self-checking bench for trap_scheduler.
module tb_trap_scheduler;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   n;
    int   ticks;

    trap_scheduler_if #(.TIMER_W(16)) bus_if ();

    trap_scheduler #(.TIMER_W(16), .TMO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        bus_if.io_violation    = 1'b0;
        bus_if.irq_sys_n       = 1'b1;
        bus_if.trap_state      = 1'b0;
        bus_if.virtual_enabled = 1'b0;
        bus_if.timer_reload    = 16'd0;
        bus_if.sw_set          = 1'b0;
        bus_if.cause_clr       = 4'b0000;
        #2;
        chk("rst_req",     bus_if.trap_req,    1'b0);
        chk("rst_cause",   bus_if.trap_cause,  2'd0);
        chk("rst_pending", bus_if.pending,     4'b0000);
        chk("rst_tick",    bus_if.timer_tick,  1'b0);
        chk("rst_tmo",     bus_if.req_timeout, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Reset mid-request
        bus_if.virtual_enabled = 1'b1;
        tick();
        bus_if.sw_set = 1'b1;
        tick();
        bus_if.sw_set = 1'b0;
        chk("sw_pending", bus_if.pending, 4'b1000);
        tick();
        chk("sw_req",   bus_if.trap_req,   1'b1);
        chk("sw_cause", bus_if.trap_cause, 2'd3);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_req",     bus_if.trap_req,   1'b0);
        chk("arst_pending", bus_if.pending,    4'b0000);
        chk("arst_cause",   bus_if.trap_cause, 2'd0);
        #1;
        rst = 1'b0;
        tick();

        // Simultaneous causes: io is driven one clock ahead so both pending
        // bits appear on the same edge (io path is one flop deeper).
        bus_if.io_violation = 1'b1;
        tick();
        bus_if.irq_sys_n = 1'b0;
        tick();
        bus_if.io_violation = 1'b0;
        tick();
        chk("both_pending", bus_if.pending, 4'b0011);
        chk("both_noreq",   bus_if.trap_req, 1'b0);
        tick();
        chk("both_req",   bus_if.trap_req,   1'b1);
        chk("both_cause", bus_if.trap_cause, 2'd0);
        bus_if.trap_state = 1'b1;
        tick();
        tick();
        chk("ack_req_e2", bus_if.trap_req, 1'b1);
        tick();
        chk("ack_req_e3", bus_if.trap_req, 1'b0);
        chk("trap_cause_hold", bus_if.trap_cause, 2'd0);
        bus_if.trap_state = 1'b0;
        bus_if.cause_clr  = 4'b0001;
        tick();
        bus_if.cause_clr = 4'b0000;
        chk("clr_io_pending", bus_if.pending, 4'b0010);
        tick();
        tick();
        tick();
        chk("release_gap_req", bus_if.trap_req, 1'b0);
        tick();
        chk("irq_req",   bus_if.trap_req,   1'b1);
        chk("irq_cause", bus_if.trap_cause, 2'd1);
        bus_if.virtual_enabled = 1'b0;
        bus_if.irq_sys_n       = 1'b1;
        tick();
        tick();
        tick();
        chk("clean1_pending", bus_if.pending,  4'b0000);
        chk("clean1_req",     bus_if.trap_req, 1'b0);

        // Timer: reload 5 -> tick every 5 clocks
        bus_if.virtual_enabled = 1'b1;
        bus_if.timer_reload    = 16'd5;
        tick();
        tick();
        tick();
        tick();
        chk("tmr_no_tick_early", bus_if.timer_tick, 1'b0);
        tick();
        chk("tmr_tick1",    bus_if.timer_tick, 1'b1);
        chk("tmr_pending",  bus_if.pending,    4'b0100);
        tick();
        chk("tmr_req",   bus_if.trap_req,   1'b1);
        chk("tmr_cause", bus_if.trap_cause, 2'd2);
        chk("tmr_tick_pulse", bus_if.timer_tick, 1'b0);
        tick();
        tick();
        tick();
        chk("tmr_no_tick_mid", bus_if.timer_tick, 1'b0);
        tick();
        chk("tmr_tick2", bus_if.timer_tick, 1'b1);
        bus_if.trap_state = 1'b1;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_if.timer_tick) ticks++;
        end
        chk("tmr_hold_ticks", ticks, 0);
        chk("tmr_hold_req",   bus_if.trap_req, 1'b0);
        bus_if.trap_state = 1'b0;
        ticks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_if.timer_tick) ticks++;
        end
        chk("tmr_resume_quiet", ticks, 0);
        tick();
        chk("tmr_resume_tick", bus_if.timer_tick, 1'b1);
        bus_if.virtual_enabled = 1'b0;
        bus_if.timer_reload    = 16'd0;
        tick();
        tick();
        tick();
        chk("clean2_pending", bus_if.pending,    4'b0000);
        chk("clean2_tick",    bus_if.timer_tick, 1'b0);
        bus_if.virtual_enabled = 1'b1;

        // Set/clear collision, io edge during trap, stale cause
        bus_if.sw_set    = 1'b1;
        bus_if.cause_clr = 4'b1000;
        tick();
        bus_if.sw_set    = 1'b0;
        bus_if.cause_clr = 4'b0000;
        chk("setclr_pending", bus_if.pending, 4'b1000);
        bus_if.trap_state = 1'b1;
        tick();
        chk("setclr_req", bus_if.trap_req, 1'b1);
        tick();
        tick();
        chk("setclr_trap_req", bus_if.trap_req,   1'b0);
        chk("setclr_cause",    bus_if.trap_cause, 2'd3);
        bus_if.io_violation = 1'b1;
        tick();
        tick();
        bus_if.io_violation = 1'b0;
        tick();
        tick();
        chk("io_in_trap_pending", bus_if.pending, 4'b1000);
        bus_if.cause_clr = 4'b1000;
        tick();
        bus_if.cause_clr = 4'b0000;
        chk("stale_pending", bus_if.pending,    4'b0000);
        chk("stale_cause",   bus_if.trap_cause, 2'd3);
        bus_if.trap_state = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("idle_no_req", bus_if.trap_req, 1'b0);

        // Request timeout (TMO_W = 8)
        bus_if.sw_set = 1'b1;
        tick();
        bus_if.sw_set = 1'b0;
        tick();
        chk("tmo_req",    bus_if.trap_req,    1'b1);
        chk("tmo_before", bus_if.req_timeout, 1'b0);
        n = 0;
        while (!bus_if.req_timeout && n < 300) begin
            tick();
            n++;
        end
        if (!(n == 255 || n == 256)) begin
            $display("timeout seen after %0d clocks in REQ", n);
        end
        chk("tmo_window", (n == 255 || n == 256), 1'b1);
        chk("tmo_drop_req", bus_if.trap_req, 1'b0);
        tick();
        chk("tmo_rereq",  bus_if.trap_req,    1'b1);
        chk("tmo_sticky", bus_if.req_timeout, 1'b1);

        // Virtualization off while trapped
        bus_if.trap_state = 1'b1;
        tick();
        tick();
        tick();
        chk("voff_trap_req", bus_if.trap_req, 1'b0);
        bus_if.irq_sys_n = 1'b0;
        tick();
        tick();
        chk("voff_pre_pending", bus_if.pending, 4'b1010);
        bus_if.virtual_enabled = 1'b0;
        tick();
        chk("voff_pending", bus_if.pending,     4'b0010);
        chk("voff_req",     bus_if.trap_req,    1'b0);
        chk("voff_tmo",     bus_if.req_timeout, 1'b1);
        bus_if.trap_state = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("voff_still_noreq", bus_if.trap_req, 1'b0);
        chk("voff_irq_follow",  bus_if.pending,  4'b0010);
        bus_if.irq_sys_n = 1'b1;
        tick();
        tick();
        chk("voff_irq_gone", bus_if.pending, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
